instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage of the 16-bit MIPS pipeline.
// Owns the program counter, addresses the instruction ROM, and captures the
// returned word into the IF/ID register. Handles stalls, redirects and halt.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc                registered byte address to the ROM
//   instruction       ROM data for pc (combinational, same cycle)
//   stall             hold pc and IF/ID
//   redirect_valid/pc branch/jump redirect; flushes IF/ID
//   halt_req          enter HALT at the next edge
//   if_id_instr/pc    captured instruction and its address
//   if_id_valid       IF/ID holds a real instruction
//   halted            high while in HALT
//   misalign_err      sticky flag for odd redirect targets
//   fetch_count       count of captured instructions (wraps)
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter logic [15:0] PC_LIMIT = 16'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  input  logic [15:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt_req,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   pc_next;
  logic [W-1:0]   instr_next;
  logic [W-1:0]   if_pc_next;
  logic [W-1:0]   count_next;
  logic           valid_next;
  logic           halted_next;
  logic           misalign_next;
  logic [W-1:0]   redirect_target;

  // Redirect targets are forced to halfword alignment; the odd bit only flags.
  assign redirect_target = {redirect_pc[W-1:1], 1'b0};

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_id_instr  <= '0;
      if_id_pc     <= '0;
      if_id_valid  <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      if_id_instr  <= instr_next;
      if_id_pc     <= if_pc_next;
      if_id_valid  <= valid_next;
      halted       <= halted_next;
      misalign_err <= misalign_next;
      fetch_count  <= count_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    instr_next    = if_id_instr;
    if_pc_next    = if_id_pc;
    valid_next    = if_id_valid;
    misalign_next = misalign_err;
    count_next    = fetch_count;

    case (state)
      BOOT: begin
        valid_next = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_next       = redirect_target;
          valid_next    = 1'b0;
          instr_next    = '0;
          misalign_next = misalign_err | redirect_pc[0];
        end else if (halt_req || (pc >= PC_LIMIT)) begin
          // Out-of-range fetch halts without capturing the ROM output.
          state_next = HALT;
          valid_next = 1'b0;
        end else if (!stall) begin
          instr_next = instruction;
          if_pc_next = pc;
          valid_next = 1'b1;
          pc_next    = pc + W'(2);
          count_next = fetch_count + W'(1);
        end
      end
      HALT: begin
        valid_next = 1'b0;
        if (redirect_valid) begin
          state_next    = RUN;
          pc_next       = redirect_target;
          instr_next    = '0;
          misalign_next = misalign_err | redirect_pc[0];
        end
      end
      default: begin
        state_next = BOOT;
        valid_next = 1'b0;
      end
    endcase

    halted_next = (state_next == HALT);
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int checks;
  int failures;
  logic [31:0] sb[$];
  logic        zero_word;

  instr_fetch #(.RESET_PC(16'd0), .PC_LIMIT(16'd32)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .halted(halted), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: ROM[i] = i + 16'h1000, optional zero override
  always_comb begin
    if (zero_word) instruction = 16'h0000;
    else if (pc < 16'd32) instruction = 16'h1000 + 16'(pc[4:1]);
    else instruction = 16'hDEAD;
  end

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return 16'h1000 + 16'(a[4:1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0; zero_word = 0;
    sb.delete();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Runs n fetches from address start, pushing and popping the scoreboard
  task automatic run_fetches(input int n, input logic [15:0] start);
    logic [31:0] e;
    logic [15:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back({a, rom_word(a)});
      tick();
      checks++;
      if (!if_id_valid || sb.size() == 0) begin
        failures++;
        $display("FAIL run_fetch valid: got %0b want 1 (a=%h)", if_id_valid, a);
      end else begin
        e = sb.pop_front();
        if ({if_id_pc, if_id_instr} !== e) begin
          failures++;
          $display("FAIL run_fetch data: got pc=%h instr=%h want %h", if_id_pc, if_id_instr, e);
        end
      end
      a = a + 16'd2;
    end
  endtask

  task automatic test_reset();
    rst_n = 1; stall = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0; zero_word = 0;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({pc, if_id_instr, if_id_pc, if_id_valid, halted, misalign_err, fetch_count} !== 67'd0) begin
      failures++;
      $display("FAIL reset_values: pc=%h instr=%h ifpc=%h v=%b h=%b m=%b cnt=%h want all 0",
               pc, if_id_instr, if_id_pc, if_id_valid, halted, misalign_err, fetch_count);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_free_run();
    do_reset();
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || pc !== 16'd0) begin
      failures++;
      $display("FAIL boot_cycle: valid=%b pc=%h want 0/0000", if_id_valid, pc);
    end
    run_fetches(16, 16'd0);
    checks++;
    if (pc !== 16'd32) begin
      failures++;
      $display("FAIL free_run_pc: got %h want 0020", pc);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || if_id_valid !== 1'b0 || fetch_count !== 16'd16 || pc !== 16'd32) begin
      failures++;
      $display("FAIL limit_halt: halted=%b valid=%b cnt=%0d pc=%h want 1/0/16/0020",
               halted, if_id_valid, fetch_count, pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    run_fetches(3, 16'd0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 16'd6 || if_id_pc !== 16'd4 || if_id_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold: pc=%h ifpc=%h valid=%b want 0006/0004/1", pc, if_id_pc, if_id_valid);
      end
    end
    stall = 0;
    run_fetches(2, 16'd6);
    checks++;
    if (fetch_count !== 16'd5) begin
      failures++;
      $display("FAIL stall_count: got %0d want 5", fetch_count);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    tick();
    run_fetches(7, 16'd0);
    stall = 1; redirect_valid = 1; redirect_pc = 16'h0006;
    tick();
    stall = 0; redirect_valid = 0;
    checks++;
    if (pc !== 16'd6 || if_id_valid !== 1'b0 || if_id_instr !== 16'd0) begin
      failures++;
      $display("FAIL redirect_flush: pc=%h valid=%b instr=%h want 0006/0/0000", pc, if_id_valid, if_id_instr);
    end
    run_fetches(1, 16'd6);
  endtask

  task automatic test_misalign();
    do_reset();
    tick();
    run_fetches(2, 16'd0);
    redirect_valid = 1; redirect_pc = 16'h0015;
    tick();
    checks++;
    if (pc !== 16'h0014 || misalign_err !== 1'b1) begin
      failures++;
      $display("FAIL misalign_set: pc=%h err=%b want 0014/1", pc, misalign_err);
    end
    redirect_pc = 16'h0004;
    tick();
    redirect_valid = 0;
    checks++;
    if (pc !== 16'h0004 || misalign_err !== 1'b1) begin
      failures++;
      $display("FAIL misalign_sticky: pc=%h err=%b want 0004/1", pc, misalign_err);
    end
    run_fetches(1, 16'd4);
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    run_fetches(5, 16'd0);
    halt_req = 1;
    tick();
    halt_req = 0;
    checks++;
    if (halted !== 1'b1 || if_id_valid !== 1'b0 || pc !== 16'd10) begin
      failures++;
      $display("FAIL halt_enter: halted=%b valid=%b pc=%h want 1/0/000a", halted, if_id_valid, pc);
    end
    for (int i = 0; i < 5; i++) begin
      stall = ~stall;
      halt_req = i[0];
      tick();
      checks++;
      if (pc !== 16'd10 || halted !== 1'b1 || if_id_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold: pc=%h halted=%b valid=%b want 000a/1/0", pc, halted, if_id_valid);
      end
    end
    stall = 0; halt_req = 0;
    redirect_valid = 1; redirect_pc = 16'h0000;
    tick();
    redirect_valid = 0;
    checks++;
    if (halted !== 1'b0 || pc !== 16'd0 || if_id_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_exit: halted=%b pc=%h valid=%b want 0/0000/0", halted, pc, if_id_valid);
    end
    run_fetches(1, 16'd0);
    checks++;
    if (fetch_count !== 16'd6) begin
      failures++;
      $display("FAIL halt_count: got %0d want 6", fetch_count);
    end
  endtask

  task automatic test_zero_instr();
    logic [31:0] e;
    do_reset();
    tick();
    run_fetches(1, 16'd0);
    zero_word = 1;
    sb.push_back({16'd2, 16'h0000});
    tick();
    zero_word = 0;
    checks++;
    e = sb.pop_front();
    if (if_id_valid !== 1'b1 || {if_id_pc, if_id_instr} !== e) begin
      failures++;
      $display("FAIL zero_instr: valid=%b pc=%h instr=%h want 1/%h", if_id_valid, if_id_pc, if_id_instr, e);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    run_fetches(10, 16'd0);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({pc, if_id_instr, if_id_pc, if_id_valid, halted, misalign_err, fetch_count} !== 67'd0) begin
      failures++;
      $display("FAIL async_reset: pc=%h instr=%h ifpc=%h v=%b h=%b m=%b cnt=%h want all 0",
               pc, if_id_instr, if_id_pc, if_id_valid, halted, misalign_err, fetch_count);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || pc !== 16'd0) begin
      failures++;
      $display("FAIL async_boot: valid=%b pc=%h want 0/0000", if_id_valid, pc);
    end
    run_fetches(2, 16'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_halt();
    test_zero_instr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
